choose_grid_scene: RTL

Parametrised sprite-selection scene for the VGA path. It draws a ROWS×COLS grid of tiles read from a tile-sheet ROM. A cursor moves over the grid in response to key pulses and is highlighted with a blinking frame. A confirmed choice is handed to the game FSM through a valid/ack handshake. The block sits between the h/v counter, the sprite ROM and the VGA colour mux, and replaces the fixed 2×4 chooser with a registered pipeline and real cursor control.

---
 rtl/choose_grid_pkg.sv | 27 ++
 rtl/choose_grid_cursor.sv | 125 ++++++++++++
 rtl/choose_grid_scene.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/choose_grid_pkg.sv
// Shared types and constants for the sprite-selection grid scene.
package choose_grid_pkg;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned PIX_W  = 12;
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned ID_W   = 8;

  typedef enum logic {BROWSE, HOLD} state_e;
  typedef enum logic [2:0] {MV_NONE, MV_UP, MV_DOWN, MV_LEFT, MV_RIGHT} move_e;
  typedef enum logic [1:0] {PC_BG, PC_TILE, PC_FRAME} pix_class_e;

  localparam logic [PIX_W-1:0] COL_FRAME = 12'h000;
  localparam logic [PIX_W-1:0] COL_BG    = 12'hFFF;

  // Index width for a count of n, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sheet address of the top-left texel of tile k (row-major sheet layout).
  function automatic logic [ADDR_W-1:0] tile_base(input int unsigned k, input int unsigned spr,
                                                  input int unsigned img_tile, input int unsigned img_w);
    return ADDR_W'((k % spr) * img_tile + img_w * ((k / spr) * img_tile));
  endfunction

endpackage

// File: rtl/choose_grid_cursor.sv
// Cursor FSM: key decode, frame-synchronous pending move, wrapping cursor, handshake, blink.
// Optional blink of the frame in BROWSE is enabled by CHOOSE_BLINK_EN.
module choose_grid_cursor
  import choose_grid_pkg::*;
#(
  parameter int unsigned COLS         = 4,
  parameter int unsigned ROWS         = 2,
  parameter int unsigned BLINK_FRAMES = 30,
  localparam int unsigned RW = idx_w(ROWS),
  localparam int unsigned CW = idx_w(COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_frame_tick,
  input  logic            i_key_up,
  input  logic            i_key_down,
  input  logic            i_key_left,
  input  logic            i_key_right,
  input  logic            i_key_confirm,
  input  logic            i_key_cancel,
  input  logic            i_sel_ack,
  output logic [RW-1:0]   o_row,
  output logic [CW-1:0]   o_col,
  output logic            o_frame_visible_c,
  output logic            o_sel_valid,
  output logic [ID_W-1:0] o_sel_id
);

  if (BLINK_FRAMES == 0) begin : g_err_blink
    $error("BLINK_FRAMES must be non-zero");
  end

  state_e          r_state, w_state_nxt;
  move_e           r_pend, w_pend_nxt, w_move;
  logic [RW-1:0]   r_row, w_row_nxt;
  logic [CW-1:0]   r_col, w_col_nxt;
  logic [ID_W-1:0] r_sel_id;
  logic            w_confirm, w_cancel, w_apply;

  // Key priority decode, state transitions and the move applied on frame_tick.
  always_comb begin
    w_confirm   = 1'b0;
    w_cancel    = 1'b0;
    w_move      = MV_NONE;
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;

    if (i_key_confirm)    w_confirm = 1'b1;
    else if (i_key_cancel) w_cancel = 1'b1;
    else if (i_key_up)     w_move   = MV_UP;
    else if (i_key_down)   w_move   = MV_DOWN;
    else if (i_key_left)   w_move   = MV_LEFT;
    else if (i_key_right)  w_move   = MV_RIGHT;

    case (r_state)
      BROWSE:  if (w_confirm) w_state_nxt = HOLD;
      HOLD:    if (i_sel_ack || w_cancel) w_state_nxt = BROWSE;
      default: w_state_nxt = BROWSE;
    endcase

    if (r_state == HOLD || w_confirm) w_pend_nxt = MV_NONE;
    else if (w_move != MV_NONE)       w_pend_nxt = w_move;
    else if (i_frame_tick)            w_pend_nxt = MV_NONE;

    w_apply = i_frame_tick && (r_state == BROWSE) && !w_confirm;
    if (w_apply) begin
      case (r_pend)
        MV_UP:    w_row_nxt = (r_row == '0) ? RW'(ROWS - 1) : r_row - RW'(1);
        MV_DOWN:  w_row_nxt = (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
        MV_LEFT:  w_col_nxt = (r_col == '0) ? CW'(COLS - 1) : r_col - CW'(1);
        MV_RIGHT: w_col_nxt = (r_col == CW'(COLS - 1)) ? '0 : r_col + CW'(1);
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= BROWSE;
      r_pend   <= MV_NONE;
      r_row    <= '0;
      r_col    <= '0;
      r_sel_id <= ID_W'(1);
    end else begin
      r_state  <= w_state_nxt;
      r_pend   <= w_pend_nxt;
      r_row    <= w_row_nxt;
      r_col    <= w_col_nxt;
      r_sel_id <= ID_W'(32'(w_row_nxt) * COLS + 32'(w_col_nxt) + 32'd1);
    end
  end

`ifdef CHOOSE_BLINK_EN
  localparam int unsigned BW = idx_w(BLINK_FRAMES);
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;

  // Phase flips after every BLINK_FRAMES frame ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (i_frame_tick) begin
      if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end
  end

  assign o_frame_visible_c = (r_state == HOLD) || r_phase;
`else
  assign o_frame_visible_c = 1'b1;
`endif

  assign o_row       = r_row;
  assign o_col       = r_col;
  assign o_sel_valid = (r_state == HOLD);
  assign o_sel_id    = r_sel_id;

endmodule

// File: rtl/choose_grid_scene.sv
// Grid chooser scene: tile/frame classification, sheet address and 2-stage pixel pipeline.
// Frame blinking in BROWSE is enabled by defining CHOOSE_BLINK_EN.
module choose_grid_scene
  import choose_grid_pkg::*;
#(
  parameter int unsigned COLS         = 4,
  parameter int unsigned ROWS         = 2,
  parameter int unsigned TILE         = 120,
  parameter int unsigned SHIFT        = 1,
  parameter int unsigned ORIGIN_H     = 20,
  parameter int unsigned ORIGIN_V     = 80,
  parameter int unsigned PITCH_H      = 160,
  parameter int unsigned PITCH_V      = 160,
  parameter int unsigned IMG_W        = 480,
  parameter int unsigned IMG_H        = 120,
  parameter int unsigned FRAME_T      = 2,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              key_up,
  input  logic              key_down,
  input  logic              key_left,
  input  logic              key_right,
  input  logic              key_confirm,
  input  logic              key_cancel,
  input  logic [CNT_W-1:0]  h_cnt,
  input  logic [CNT_W-1:0]  v_cnt,
  input  logic [PIX_W-1:0]  mem_data,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [PIX_W-1:0]  vga_data,
  output logic [ID_W-1:0]   sel_id,
  output logic              sel_valid,
  input  logic              sel_ack
);

  localparam int unsigned IMG_TILE = TILE >> SHIFT;
  localparam int unsigned SPR      = IMG_W / IMG_TILE;
  localparam int unsigned SPC      = IMG_H / IMG_TILE;
  localparam int unsigned RW       = idx_w(ROWS);
  localparam int unsigned CW       = idx_w(COLS);

  if (ORIGIN_H < FRAME_T || ORIGIN_V < FRAME_T) begin : g_err_origin
    $error("origin leaves no room for the frame ring");
  end
  if (PITCH_H < TILE + 2 * FRAME_T || PITCH_V < TILE + 2 * FRAME_T) begin : g_err_pitch
    $error("pitch too small for tile plus frame");
  end
  if (ROWS * COLS > SPR * SPC) begin : g_err_sheet
    $error("tile sheet holds fewer tiles than the grid");
  end
  if (ROWS * COLS > 255) begin : g_err_ids
    $error("grid too large for an 8-bit id");
  end

  logic [RW-1:0]     w_cur_row;
  logic [CW-1:0]     w_cur_col;
  logic              w_frame_vis;

  choose_grid_cursor #(
    .COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(BLINK_FRAMES)
  ) u_cursor (
    .clk(clk), .rst(rst), .i_frame_tick(frame_tick),
    .i_key_up(key_up), .i_key_down(key_down), .i_key_left(key_left),
    .i_key_right(key_right), .i_key_confirm(key_confirm), .i_key_cancel(key_cancel),
    .i_sel_ack(sel_ack), .o_row(w_cur_row), .o_col(w_cur_col),
    .o_frame_visible_c(w_frame_vis), .o_sel_valid(sel_valid), .o_sel_id(sel_id)
  );

  logic [ADDR_W-1:0] w_h, w_v;
  logic [ROWS-1:0]   w_row_hit, w_row_ring;
  logic [COLS-1:0]   w_col_hit, w_col_ring;
  logic [ADDR_W-1:0] w_sy [ROWS];
  logic [ADDR_W-1:0] w_sx [COLS];

  assign w_h = ADDR_W'(h_cnt);
  assign w_v = ADDR_W'(v_cnt);

  // Per-row span comparators; the ring span extends FRAME_T beyond the tile edge.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam int unsigned Y0 = ORIGIN_V + r * PITCH_V;
    assign w_row_hit[r]  = (w_v >= ADDR_W'(Y0)) && (w_v < ADDR_W'(Y0 + TILE));
    assign w_row_ring[r] = (w_v >= ADDR_W'(Y0 - FRAME_T)) && (w_v < ADDR_W'(Y0 + TILE + FRAME_T));
    assign w_sy[r]       = (w_v - ADDR_W'(Y0)) >> SHIFT;
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int unsigned X0 = ORIGIN_H + c * PITCH_H;
    assign w_col_hit[c]  = (w_h >= ADDR_W'(X0)) && (w_h < ADDR_W'(X0 + TILE));
    assign w_col_ring[c] = (w_h >= ADDR_W'(X0 - FRAME_T)) && (w_h < ADDR_W'(X0 + TILE + FRAME_T));
    assign w_sx[c]       = (w_h - ADDR_W'(X0)) >> SHIFT;
  end

  logic              w_hit, w_ring;
  logic [ADDR_W-1:0] w_addr;
  pix_class_e        w_class;

  // Tiles never overlap, so at most one hit contributes an address.
  always_comb begin
    w_hit  = 1'b0;
    w_addr = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (w_row_hit[r] && w_col_hit[c]) begin
          w_hit  = 1'b1;
          w_addr = tile_base(r * COLS + c, SPR, IMG_TILE, IMG_W) + w_sx[c]
                 + ADDR_W'(IMG_W) * w_sy[r];
        end
      end
    end
    w_ring  = w_frame_vis && w_row_ring[w_cur_row] && w_col_ring[w_cur_col]
           && !(w_row_hit[w_cur_row] && w_col_hit[w_cur_col]);
    w_class = w_ring ? PC_FRAME : (w_hit ? PC_TILE : PC_BG);
  end

  logic [ADDR_W-1:0] r_addr;
  pix_class_e        r_class;
  logic [PIX_W-1:0]  r_vga;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_class <= PC_BG;
      r_vga   <= COL_FRAME;
    end else begin
      r_addr  <= w_addr;
      r_class <= w_class;
      case (r_class)
        PC_FRAME: r_vga <= COL_FRAME;
        PC_TILE:  r_vga <= mem_data;
        default:  r_vga <= COL_BG;
      endcase
    end
  end

  assign pixel_addr = r_addr;
  assign vga_data   = r_vga;

endmodule
